// File: rtl/direct_router.sv
// Routes addressed packets from the kernel-side direct stream either to the LAN
// port (with a prepended routing header beat) or back to the direct port.
module direct_router #(
    parameter int DATA_WIDTH      = 512,
    localparam int KEEP_WIDTH     = DATA_WIDTH / 8,
    parameter int NODE_WIDTH      = 8,
    parameter int KERN_WIDTH      = 8,
    localparam int DEST_WIDTH     = NODE_WIDTH + KERN_WIDTH,
    parameter int USER_WIDTH      = 48,
    parameter int NODE_ID         = 0,
    parameter int ENABLE_LOOPBACK = 1,
    parameter int MAX_BEATS       = 256,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    output logic                  direct_rx_tready,
    input  logic                  direct_rx_tvalid,
    input  logic                  direct_rx_tlast,
    input  logic [DATA_WIDTH-1:0] direct_rx_tdata,
    input  logic [KEEP_WIDTH-1:0] direct_rx_tkeep,
    input  logic [DEST_WIDTH-1:0] direct_rx_tdest,
    input  logic [USER_WIDTH-1:0] direct_rx_tuser,

    input  logic                  lan_tx_tready,
    output logic                  lan_tx_tvalid,
    output logic                  lan_tx_tlast,
    output logic [DATA_WIDTH-1:0] lan_tx_tdata,
    output logic [KEEP_WIDTH-1:0] lan_tx_tkeep,
    output logic [NODE_WIDTH-1:0] lan_tx_tdest,
    output logic [KERN_WIDTH-1:0] lan_tx_tid,
    output logic [NODE_WIDTH-1:0] lan_tx_tuser,

    input  logic                  direct_tx_tready,
    output logic                  direct_tx_tvalid,
    output logic                  direct_tx_tlast,
    output logic [DATA_WIDTH-1:0] direct_tx_tdata,
    output logic [KEEP_WIDTH-1:0] direct_tx_tkeep,
    output logic [DEST_WIDTH-1:0] direct_tx_tdest,
    output logic [USER_WIDTH-1:0] direct_tx_tuser,

    output logic [CNT_WIDTH-1:0]  lan_pkt_count,
    output logic [CNT_WIDTH-1:0]  loop_pkt_count,
    output logic [CNT_WIDTH-1:0]  trunc_count
);

    // state     | meaning
    // IDLE      | waiting for the first beat of a packet, routing decision
    // LAN_BODY  | header issued, copying payload to lan_tx
    // LOOP_BODY | copying payload to direct_tx
    // DROP      | packet truncated, discarding beats up to tlast
    typedef enum logic [1:0] {IDLE, LAN_BODY, LOOP_BODY, DROP} state_t;

    localparam int BW        = $clog2(MAX_BEATS + 1);
    localparam int HDR_BYTES = (USER_WIDTH + DEST_WIDTH) / 8;

    state_t state, state_nxt;

    logic [NODE_WIDTH-1:0] rx_node;
    logic [KERN_WIDTH-1:0] rx_kern;
    logic                  is_local;
    logic                  lan_free, loop_free;
    logic                  load_hdr, load_lan, load_loop;
    logic                  in_body, at_limit, beat_last;
    logic [BW-1:0]         beats_left;
    logic [DATA_WIDTH-1:0] hdr_data;
    logic [KEEP_WIDTH-1:0] hdr_keep;

    assign rx_node   = direct_rx_tdest[DEST_WIDTH-1:KERN_WIDTH];
    assign rx_kern   = direct_rx_tdest[KERN_WIDTH-1:0];
    assign is_local  = (ENABLE_LOOPBACK != 0) && (rx_node == NODE_WIDTH'(NODE_ID));
    assign lan_free  = !lan_tx_tvalid || lan_tx_tready;
    assign loop_free = !direct_tx_tvalid || direct_tx_tready;
    assign in_body   = (state == LAN_BODY) || (state == LOOP_BODY);
    // beats_left counts down from MAX_BEATS; reaching 1 means this beat is the last allowed
    assign at_limit  = (beats_left == BW'(1));
    assign beat_last = direct_rx_tlast || (in_body && at_limit);

    always_comb begin
        hdr_data = '0;
        hdr_data[USER_WIDTH-1:0]          = direct_rx_tuser;
        hdr_data[USER_WIDTH +: DEST_WIDTH] = direct_rx_tdest;
        hdr_keep = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            hdr_keep[i] = (i < HDR_BYTES);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (load_loop && !direct_rx_tlast) state_nxt = LOOP_BODY;
                else if (load_hdr)                 state_nxt = LAN_BODY;
            end
            LAN_BODY, LOOP_BODY: begin
                if (load_lan || load_loop) begin
                    if (direct_rx_tlast)  state_nxt = IDLE;
                    else if (at_limit)    state_nxt = DROP;
                end
            end
            DROP: begin
                if (direct_rx_tvalid && direct_rx_tlast) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A local packet waits for the loopback stage rather than spilling onto the LAN.
    always_comb begin
        direct_rx_tready = 1'b0;
        load_hdr         = 1'b0;
        load_lan         = 1'b0;
        load_loop        = 1'b0;
        case (state)
            IDLE: begin
                if (direct_rx_tvalid) begin
                    if (is_local) begin
                        if (loop_free) begin
                            direct_rx_tready = 1'b1;
                            load_loop        = 1'b1;
                        end
                    end else if (lan_free) begin
                        load_hdr = 1'b1;
                    end
                end
            end
            LAN_BODY: begin
                direct_rx_tready = lan_free;
                load_lan         = direct_rx_tvalid && lan_free;
            end
            LOOP_BODY: begin
                direct_rx_tready = loop_free;
                load_loop        = direct_rx_tvalid && loop_free;
            end
            DROP: direct_rx_tready = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beats_left <= '0;
        end else if (load_hdr) begin
            beats_left <= BW'(MAX_BEATS);
        end else if (load_loop && state == IDLE) begin
            beats_left <= BW'(MAX_BEATS - 1);
        end else if (load_lan || load_loop) begin
            beats_left <= beats_left - BW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lan_tx_tvalid <= 1'b0;
            lan_tx_tlast  <= 1'b0;
            lan_tx_tdata  <= '0;
            lan_tx_tkeep  <= '0;
            lan_tx_tdest  <= '0;
            lan_tx_tid    <= '0;
            lan_tx_tuser  <= '0;
        end else if (load_hdr) begin
            lan_tx_tvalid <= 1'b1;
            lan_tx_tlast  <= 1'b0;
            lan_tx_tdata  <= hdr_data;
            lan_tx_tkeep  <= hdr_keep;
            lan_tx_tdest  <= rx_node;
            lan_tx_tid    <= rx_kern;
            lan_tx_tuser  <= NODE_WIDTH'(NODE_ID);
        end else if (load_lan) begin
            lan_tx_tvalid <= 1'b1;
            lan_tx_tlast  <= beat_last;
            lan_tx_tdata  <= direct_rx_tdata;
            lan_tx_tkeep  <= direct_rx_tkeep;
        end else if (lan_tx_tready) begin
            lan_tx_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            direct_tx_tvalid <= 1'b0;
            direct_tx_tlast  <= 1'b0;
            direct_tx_tdata  <= '0;
            direct_tx_tkeep  <= '0;
            direct_tx_tdest  <= '0;
            direct_tx_tuser  <= '0;
        end else if (load_loop) begin
            direct_tx_tvalid <= 1'b1;
            direct_tx_tlast  <= beat_last;
            direct_tx_tdata  <= direct_rx_tdata;
            direct_tx_tkeep  <= direct_rx_tkeep;
            direct_tx_tdest  <= direct_rx_tdest;
            direct_tx_tuser  <= direct_rx_tuser;
        end else if (direct_tx_tready) begin
            direct_tx_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lan_pkt_count  <= '0;
            loop_pkt_count <= '0;
            trunc_count    <= '0;
        end else begin
            if (load_lan && beat_last)  lan_pkt_count  <= lan_pkt_count + CNT_WIDTH'(1);
            if (load_loop && beat_last) loop_pkt_count <= loop_pkt_count + CNT_WIDTH'(1);
            if ((load_lan || load_loop) && in_body && at_limit && !direct_rx_tlast)
                trunc_count <= trunc_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_direct_router.sv
// Bench for direct_router: directed vector table, hand-timed corner sequences and
// randomized traffic compared against a packet-level reference model.
module tb_direct_router;
    localparam int DW = 128;
    localparam int KW = DW / 8;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic [15:0]   dest;
        logic [47:0]   user;
        int            cyc;
    } beat_t;

    typedef struct {
        logic        sel;
        logic [15:0] dest;
        logic [47:0] user;
        int          len;
        int          lan_mode;
        int          n_lan;
        int          n_loop;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          sel;
    logic          rx_tvalid, rx_tlast;
    logic [DW-1:0] rx_tdata;
    logic [KW-1:0] rx_tkeep;
    logic [15:0]   rx_tdest;
    logic [47:0]   rx_tuser;
    logic          lan_rdy, loop_rdy;

    logic          rx_v_w [2];
    logic          rx_rdy_w [2];
    logic          lan_v_w [2], lan_l_w [2];
    logic [DW-1:0] lan_d_w [2];
    logic [KW-1:0] lan_k_w [2];
    logic [7:0]    lan_dest_w [2], lan_tid_w [2], lan_user_w [2];
    logic          loop_v_w [2], loop_l_w [2];
    logic [DW-1:0] loop_d_w [2];
    logic [KW-1:0] loop_k_w [2];
    logic [15:0]   loop_dest_w [2];
    logic [47:0]   loop_user_w [2];
    logic [31:0]   lan_cnt_w [2], loop_cnt_w [2], trunc_cnt_w [2];

    assign rx_v_w[0] = rx_tvalid & ~sel;
    assign rx_v_w[1] = rx_tvalid & sel;

    // Instance 0: loopback on, MAX_BEATS=16. Instance 1: loopback off, MAX_BEATS=4.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        direct_router #(
            .DATA_WIDTH(DW), .NODE_WIDTH(8), .KERN_WIDTH(8), .USER_WIDTH(48),
            .NODE_ID(1), .ENABLE_LOOPBACK(g == 0 ? 1 : 0),
            .MAX_BEATS(g == 0 ? 16 : 4), .CNT_WIDTH(32)
        ) u_dut (
            .clk(clk), .rst(rst),
            .direct_rx_tready(rx_rdy_w[g]), .direct_rx_tvalid(rx_v_w[g]),
            .direct_rx_tlast(rx_tlast), .direct_rx_tdata(rx_tdata),
            .direct_rx_tkeep(rx_tkeep), .direct_rx_tdest(rx_tdest),
            .direct_rx_tuser(rx_tuser),
            .lan_tx_tready(lan_rdy), .lan_tx_tvalid(lan_v_w[g]), .lan_tx_tlast(lan_l_w[g]),
            .lan_tx_tdata(lan_d_w[g]), .lan_tx_tkeep(lan_k_w[g]), .lan_tx_tdest(lan_dest_w[g]),
            .lan_tx_tid(lan_tid_w[g]), .lan_tx_tuser(lan_user_w[g]),
            .direct_tx_tready(loop_rdy), .direct_tx_tvalid(loop_v_w[g]),
            .direct_tx_tlast(loop_l_w[g]), .direct_tx_tdata(loop_d_w[g]),
            .direct_tx_tkeep(loop_k_w[g]), .direct_tx_tdest(loop_dest_w[g]),
            .direct_tx_tuser(loop_user_w[g]),
            .lan_pkt_count(lan_cnt_w[g]), .loop_pkt_count(loop_cnt_w[g]),
            .trunc_count(trunc_cnt_w[g])
        );
    end

    wire          rx_tready = rx_rdy_w[sel];
    wire          lan_v     = lan_v_w[sel];
    wire          lan_l     = lan_l_w[sel];
    wire [DW-1:0] lan_d     = lan_d_w[sel];
    wire          loop_v    = loop_v_w[sel];

    int errors = 0;
    int checks = 0;
    int gcyc   = 0;
    int exp_lan_c [2];
    int exp_loop_c [2];
    int exp_trunc_c [2];
    beat_t in_q [$];
    beat_t exp_lan [$], exp_loop [$], got_lan [$], got_loop [$];
    vec_t  vecs [9];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic cmp_beat(input string name, input beat_t g, input beat_t e);
        checks++;
        if (g.data !== e.data || g.keep !== e.keep || g.last !== e.last ||
            g.dest !== e.dest || g.user !== e.user) begin
            errors++;
            $display("FAIL %s: got data=%h keep=%h last=%b dest=%h user=%h expected data=%h keep=%h last=%b dest=%h user=%h",
                     name, g.data, g.keep, g.last, g.dest, g.user, e.data, e.keep, e.last, e.dest, e.user);
        end
    endtask

    // Reference model: packet-level routing, header, truncation and counter rules.
    task automatic add_packet(input int d, input logic [15:0] dest, input logic [47:0] user, input int len);
        int    maxb    = (d == 0) ? 16 : 4;
        bit    local_p = (d == 0) && (dest[15:8] == 8'h01);
        beat_t ib, ob;
        if (!local_p) begin
            ob.data = '0;
            ob.data[47:0]  = user;
            ob.data[63:48] = dest;
            ob.keep = 16'h00FF;
            ob.last = 1'b0;
            ob.dest = dest;
            ob.user = 48'h1;
            ob.cyc  = 0;
            exp_lan.push_back(ob);
        end
        for (int b = 0; b < len; b++) begin
            ib.data = {$urandom(), $urandom(), $urandom(), $urandom()};
            ib.keep = (b == len - 1) ? 16'($urandom_range(1, 65535)) : 16'hFFFF;
            ib.last = (b == len - 1);
            ib.dest = dest;
            ib.user = user;
            ib.cyc  = 0;
            in_q.push_back(ib);
            if (b < maxb) begin
                ob = ib;
                ob.last = (b == len - 1) || (b == maxb - 1);
                if (local_p) exp_loop.push_back(ob);
                else begin
                    ob.user = 48'h1;
                    exp_lan.push_back(ob);
                end
            end
        end
        if (local_p) exp_loop_c[d]++;
        else         exp_lan_c[d]++;
        if (len > maxb) exp_trunc_c[d]++;
    endtask

    function automatic logic rdy_gen(input int mode, input int c);
        if (mode == 1) return (c % 2 == 0);
        if (mode == 2) return ($urandom_range(3) != 0);
        return 1'b1;
    endfunction

    function automatic beat_t lan_now();
        beat_t b;
        b.data = lan_d;
        b.keep = lan_k_w[sel];
        b.last = lan_l;
        b.dest = {lan_dest_w[sel], lan_tid_w[sel]};
        b.user = {40'h0, lan_user_w[sel]};
        b.cyc  = gcyc;
        return b;
    endfunction

    function automatic beat_t loop_now();
        beat_t b;
        b.data = loop_d_w[sel];
        b.keep = loop_k_w[sel];
        b.last = loop_l_w[sel];
        b.dest = loop_dest_w[sel];
        b.user = loop_user_w[sel];
        b.cyc  = gcyc;
        return b;
    endfunction

    task automatic drive(input beat_t b);
        rx_tdata = b.data;
        rx_tkeep = b.keep;
        rx_tlast = b.last;
        rx_tdest = b.dest;
        rx_tuser = b.user;
    endtask

    task automatic stall_chk(input string name, input bit was, input beat_t prev, input beat_t now, input logic v);
        if (was) begin
            checks++;
            if (!v || now.data !== prev.data || now.last !== prev.last || now.keep !== prev.keep) begin
                errors++;
                $display("FAIL %s: got valid=%b data=%h expected valid=1 data=%h", name, v, now.data, prev.data);
            end
        end
    endtask

    task automatic run_traffic(input int lan_mode, input int loop_mode, input int gap, input int max_cyc);
        int    cyc = 0, idle = 0;
        bit    presenting = 0, lan_st = 0, loop_st = 0;
        beat_t lan_prev, loop_prev, b;
        while ((in_q.size() > 0 || idle < 8) && cyc < max_cyc) begin
            @(negedge clk);
            if (!presenting && in_q.size() > 0 && $urandom_range(99) >= gap) presenting = 1;
            rx_tvalid = presenting;
            if (presenting) drive(in_q[0]);
            if (in_q.size() > 0) begin
                lan_rdy  = rdy_gen(lan_mode, cyc);
                loop_rdy = rdy_gen(loop_mode, cyc);
            end else begin
                lan_rdy  = 1'b1;
                loop_rdy = 1'b1;
                idle++;
            end
            #1;
            b = lan_now();
            stall_chk("lan_stall_stable", lan_st, lan_prev, b, lan_v);
            lan_st = lan_v && !lan_rdy;
            lan_prev = b;
            if (lan_v && lan_rdy) got_lan.push_back(b);
            b = loop_now();
            stall_chk("loop_stall_stable", loop_st, loop_prev, b, loop_v);
            loop_st = loop_v && !loop_rdy;
            loop_prev = b;
            if (loop_v && loop_rdy) got_loop.push_back(b);
            if (presenting && rx_tready) begin
                void'(in_q.pop_front());
                presenting = 0;
            end
            cyc++;
            gcyc++;
        end
        rx_tvalid = 1'b0;
        if (in_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL traffic_timeout: got %0d input beats left expected 0", in_q.size());
            in_q.delete();
        end
    endtask

    task automatic compare_streams(input string tag);
        chk({tag, "_lan_len"}, 128'(got_lan.size()), 128'(exp_lan.size()));
        for (int i = 0; i < got_lan.size() && i < exp_lan.size(); i++)
            cmp_beat($sformatf("%s_lan%0d", tag, i), got_lan[i], exp_lan[i]);
        chk({tag, "_loop_len"}, 128'(got_loop.size()), 128'(exp_loop.size()));
        for (int i = 0; i < got_loop.size() && i < exp_loop.size(); i++)
            cmp_beat($sformatf("%s_loop%0d", tag, i), got_loop[i], exp_loop[i]);
        chk({tag, "_lan_cnt"},   128'(lan_cnt_w[sel]),   128'(exp_lan_c[sel]));
        chk({tag, "_loop_cnt"},  128'(loop_cnt_w[sel]),  128'(exp_loop_c[sel]));
        chk({tag, "_trunc_cnt"}, 128'(trunc_cnt_w[sel]), 128'(exp_trunc_c[sel]));
        got_lan.delete();
        got_loop.delete();
        exp_lan.delete();
        exp_loop.delete();
    endtask

    initial begin
        logic [DW-1:0] d0, d1, d2;
        logic [15:0]   dst;

        vecs[0] = '{1'b0, 16'h0205, 48'hAABBCCDDEEFF, 3, 0, 4, 0};
        vecs[1] = '{1'b0, 16'h0107, 48'h112233445566, 3, 0, 0, 3};
        vecs[2] = '{1'b1, 16'h0107, 48'h112233445566, 3, 0, 4, 0};
        vecs[3] = '{1'b0, 16'h0300, 48'h0000000000A5, 8, 1, 9, 0};
        vecs[4] = '{1'b1, 16'h0205, 48'hAABBCCDDEEFF, 6, 0, 5, 0};
        vecs[5] = '{1'b1, 16'h0205, 48'hAABBCCDDEEFF, 2, 0, 3, 0};
        vecs[6] = '{1'b0, 16'h0101, 48'h000000000001, 1, 0, 0, 1};
        vecs[7] = '{1'b0, 16'h0901, 48'h000000000002, 1, 0, 2, 0};
        vecs[8] = '{1'b0, 16'h0100, 48'h000000000003, 20, 0, 0, 16};

        for (int i = 0; i < 2; i++) begin
            exp_lan_c[i] = 0; exp_loop_c[i] = 0; exp_trunc_c[i] = 0;
        end
        sel = 1'b0; rx_tvalid = 1'b0; rx_tlast = 1'b0; rx_tdata = '0; rx_tkeep = '0;
        rx_tdest = '0; rx_tuser = '0; lan_rdy = 1'b1; loop_rdy = 1'b1;

        repeat (3) @(negedge clk);
        #1;
        chk("reset_rx_tready", 128'(rx_tready), 128'(0));
        chk("reset_lan_valid", 128'(lan_v), 128'(0));
        chk("reset_loop_valid", 128'(loop_v), 128'(0));
        chk("reset_lan_data", lan_d, 128'(0));
        chk("reset_lan_cnt", 128'(lan_cnt_w[0]), 128'(0));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            sel = vecs[i].sel;
            add_packet(int'(vecs[i].sel), vecs[i].dest, vecs[i].user, vecs[i].len);
            run_traffic(vecs[i].lan_mode, 0, 0, 2000);
            chk($sformatf("vec%0d_lan_beats", i), 128'(got_lan.size()), 128'(vecs[i].n_lan));
            chk($sformatf("vec%0d_loop_beats", i), 128'(got_loop.size()), 128'(vecs[i].n_loop));
            if (i == 0 && got_lan.size() == 4) begin
                chk("hdr_data", got_lan[0].data, 128'h0000000000000000_0205AABBCCDDEEFF);
                chk("hdr_keep", 128'(got_lan[0].keep), 128'h00FF);
                chk("hdr_dest_tid", 128'(got_lan[0].dest), 128'h0205);
                chk("hdr_src_node", 128'(got_lan[0].user), 128'h01);
                chk("hdr_last", 128'(got_lan[0].last), 128'(0));
                chk("beat4_last", 128'(got_lan[3].last), 128'(1));
            end
            compare_streams($sformatf("vec%0d", i));
        end

        // LAN latency: header one cycle after presentation, payload accepted alongside it.
        sel = 1'b0;
        d0 = {$urandom(), $urandom(), $urandom(), $urandom()};
        @(negedge clk);
        rx_tdata = d0; rx_tkeep = '1; rx_tlast = 1'b1; rx_tdest = 16'h0205; rx_tuser = 48'h77;
        rx_tvalid = 1'b1; lan_rdy = 1'b1;
        #1;
        chk("lat_no_output_yet", 128'(lan_v), 128'(0));
        @(negedge clk);
        #1;
        chk("lat_hdr_valid", 128'({lan_v, lan_l}), 128'(2'b10));
        chk("lat_hdr_data", lan_d, {64'h0, 16'h0205, 48'h77});
        chk("lat_payload_accept", 128'(rx_tready), 128'(1));
        @(negedge clk);
        rx_tvalid = 1'b0;
        #1;
        chk("lat_payload_beat", {lan_v, lan_l, lan_d}, {1'b1, 1'b1, d0});
        @(negedge clk);
        #1;
        chk("lat_done", 128'(lan_v), 128'(0));
        exp_lan_c[0]++;

        // Back-to-back loopback packets of 1, 1 and 2 beats.
        add_packet(0, 16'h0101, 48'h10, 1);
        add_packet(0, 16'h0102, 48'h20, 1);
        add_packet(0, 16'h0103, 48'h30, 2);
        run_traffic(0, 0, 0, 200);
        chk("b2b_loop_beats", 128'(got_loop.size()), 128'(4));
        for (int i = 1; i < got_loop.size(); i++)
            chk($sformatf("b2b_contig%0d", i), 128'(got_loop[i].cyc - got_loop[i-1].cyc), 128'(1));
        compare_streams("b2b");

        // Reset while payload beat 2 of 5 is stalled on lan_tx.
        d0 = {$urandom(), $urandom(), $urandom(), $urandom()};
        d1 = {$urandom(), $urandom(), $urandom(), $urandom()};
        d2 = {$urandom(), $urandom(), $urandom(), $urandom()};
        @(negedge clk);
        rx_tdata = d0; rx_tkeep = '1; rx_tlast = 1'b0; rx_tdest = 16'h0205; rx_tuser = 48'h5;
        rx_tvalid = 1'b1; lan_rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rx_tdata = d1;
        @(negedge clk);
        rx_tdata = d2; lan_rdy = 1'b0;
        #1;
        chk("rst_pre_stalled_beat", {lan_v, lan_d}, {1'b1, d1});
        rst = 1'b1;
        #1;
        chk("rst_lan_valid", 128'(lan_v), 128'(0));
        chk("rst_lan_data", lan_d, 128'(0));
        chk("rst_loop_valid", 128'(loop_v), 128'(0));
        chk("rst_rx_tready", 128'(rx_tready), 128'(0));
        chk("rst_counters", {32'h0, lan_cnt_w[0], loop_cnt_w[0], trunc_cnt_w[0]}, 128'(0));
        rx_tvalid = 1'b0; lan_rdy = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_lan_c[i] = 0; exp_loop_c[i] = 0; exp_trunc_c[i] = 0;
        end
        add_packet(0, 16'h0205, 48'h123, 1);
        run_traffic(0, 0, 0, 200);
        chk("post_rst_lan_beats", 128'(got_lan.size()), 128'(2));
        compare_streams("post_rst");

        // Randomized mixed traffic with random backpressure and input gaps.
        sel = 1'b0;
        for (int p = 0; p < 30; p++) begin
            dst = {8'($urandom_range(0, 2)), 8'($urandom())};
            add_packet(0, dst, {$urandom(), 16'($urandom())}, int'($urandom_range(1, 20)));
        end
        run_traffic(2, 2, 25, 20000);
        compare_streams("rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
